// File: rtl/md_rx_arbiter.sv
// md_rx_arbiter: round-robin share of the aligner MD RX port among
// NUM_REQ masters; a grant is held for one whole valid/ready transfer.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/data/     packed per-requester MD request (slice i = req i)
//     offset/size
//   req_ready/req_err   per-requester response, only the owner sees it
//   md_rx_*             muxed MD channel to/from the aligner
//   grant               one-hot owner, 0 when idle
//   proto_err           sticky: owner dropped valid before ready
//   grant_cnt, cnt_clr  per-requester completion counters (16b each)
//
// Build option: define MD_ARB_STATS_EN to implement grant_cnt.
// Without it grant_cnt is 0 and cnt_clr is ignored.

module md_rx_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ALGN_DATA_WIDTH = 32,
  localparam int OFFW  = $clog2(ALGN_DATA_WIDTH/8),
  localparam int SIZEW = $clog2(ALGN_DATA_WIDTH/8) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ALGN_DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*OFFW-1:0]      req_offset,
  input  logic [NUM_REQ*SIZEW-1:0]     req_size,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_err,
  output logic                         md_rx_valid,
  output logic [ALGN_DATA_WIDTH-1:0]   md_rx_data,
  output logic [OFFW-1:0]              md_rx_offset,
  output logic [SIZEW-1:0]             md_rx_size,
  input  logic                         md_rx_ready,
  input  logic                         md_rx_err,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         proto_err,
  output logic [NUM_REQ*16-1:0]        grant_cnt,
  input  logic                         cnt_clr
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   gidx, gidx_n;
  logic [IW-1:0]   rr_ptr, rr_n;
  logic            perr_q, perr_n;
  logic            xfer_done;

  // First valid requester at or after ptr, wrapping.
  function automatic logic [IW-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [IW-1:0]      ptr
  );
    logic [IW-1:0] sel;
    logic          hit;
    int            idx;
    sel = ptr;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!hit && v[idx]) begin
        sel = IW'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IW-1:0] rr_next(
    input logic [IW-1:0] g
  );
    return (int'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gidx   <= '0;
      rr_ptr <= '0;
      perr_q <= 1'b0;
    end else begin
      state  <= state_n;
      gidx   <= gidx_n;
      rr_ptr <= rr_n;
      perr_q <= perr_n;
    end
  end

  // Outputs are forced low while reset is high so an in-flight
  // grant disappears immediately rather than at the next edge.
  always_comb begin
    state_n      = state;
    gidx_n       = gidx;
    rr_n         = rr_ptr;
    perr_n       = perr_q;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    req_ready    = '0;
    req_err      = '0;
    grant        = '0;
    xfer_done    = 1'b0;
    if (!reset) begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            gidx_n  = rr_pick(req_valid, rr_ptr);
            state_n = BUSY;
          end
        end
        BUSY: begin
          md_rx_valid  = req_valid[gidx];
          md_rx_data   = req_data[int'(gidx)*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
          md_rx_offset = req_offset[int'(gidx)*OFFW +: OFFW];
          md_rx_size   = req_size[int'(gidx)*SIZEW +: SIZEW];
          req_ready[gidx] = md_rx_ready;
          req_err[gidx]   = md_rx_err & md_rx_ready;
          grant[gidx]     = 1'b1;
          if (!req_valid[gidx]) begin
            perr_n  = 1'b1;
            state_n = IDLE;
            rr_n    = rr_next(gidx);
          end else if (md_rx_ready) begin
            // Owner is still valid here, so re-arbitration always
            // finds someone; it wins again only if it is alone.
            xfer_done = 1'b1;
            rr_n      = rr_next(gidx);
            gidx_n    = rr_pick(req_valid, rr_n);
          end
        end
        default: ;
      endcase
    end
  end

  assign proto_err = perr_q & ~reset;

`ifdef MD_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt_q <= '0;
    end else if (xfer_done && cnt_q[gidx] != 16'hFFFF) begin
      cnt_q[gidx] <= cnt_q[gidx] + 16'd1;
    end
  end

  assign grant_cnt = reset ? '0 : cnt_q;
`else
  logic unused_stats;
  assign unused_stats = cnt_clr ^ xfer_done;
  assign grant_cnt    = '0;
`endif

endmodule

// File: tb/tb_md_rx_arbiter.sv
// tb_md_rx_arbiter: scoreboard bench for md_rx_arbiter.
// Expected transfers are queued at drive time, popped on handshake.

module tb_md_rx_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int OFFW  = 2;
  localparam int SIZEW = 3;

  logic               clk;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N*W-1:0]     req_data;
  logic [N*OFFW-1:0]  req_offset;
  logic [N*SIZEW-1:0] req_size;
  logic [N-1:0]       req_ready;
  logic [N-1:0]       req_err;
  logic               md_rx_valid;
  logic [W-1:0]       md_rx_data;
  logic [OFFW-1:0]    md_rx_offset;
  logic [SIZEW-1:0]   md_rx_size;
  logic               md_rx_ready;
  logic               md_rx_err;
  logic [N-1:0]       grant;
  logic               proto_err;
  logic [N*16-1:0]    grant_cnt;
  logic               cnt_clr;

  md_rx_arbiter #(
    .NUM_REQ         (N),
    .ALGN_DATA_WIDTH (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_offset   (req_offset),
    .req_size     (req_size),
    .req_ready    (req_ready),
    .req_err      (req_err),
    .md_rx_valid  (md_rx_valid),
    .md_rx_data   (md_rx_data),
    .md_rx_offset (md_rx_offset),
    .md_rx_size   (md_rx_size),
    .md_rx_ready  (md_rx_ready),
    .md_rx_err    (md_rx_err),
    .grant        (grant),
    .proto_err    (proto_err),
    .grant_cnt    (grant_cnt),
    .cnt_clr      (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int               id;
    logic [W-1:0]     d;
    logic [OFFW-1:0]  o;
    logic [SIZEW-1:0] s;
  } exp_t;

  exp_t             sb[$];
  bit               sb_en = 1'b1;
  logic [W-1:0]     pd [N];
  logic [OFFW-1:0]  po [N];
  logic [SIZEW-1:0] ps [N];

  task automatic set_req(int i, logic [W-1:0] d,
                         logic [OFFW-1:0] o, logic [SIZEW-1:0] s);
    pd[i] = d;
    po[i] = o;
    ps[i] = s;
    req_data[i*W +: W]           = d;
    req_offset[i*OFFW +: OFFW]   = o;
    req_size[i*SIZEW +: SIZEW]   = s;
  endtask

  task automatic push(int i);
    exp_t e;
    e.id = i;
    e.d  = pd[i];
    e.o  = po[i];
    e.s  = ps[i];
    sb.push_back(e);
  endtask

  // Call at a falling edge; returns one cycle later, out of reset.
  task automatic do_reset();
    reset       = 1'b1;
    req_valid   = '0;
    md_rx_ready = 1'b0;
    md_rx_err   = 1'b0;
    cnt_clr     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Handshake monitor, sampled 1 time unit before the rising edge.
  always @(negedge clk) begin
    #4;
    if (sb_en && md_rx_valid && md_rx_ready) begin
      chk("sb_depth", 64'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_grant", grant, 4'b0001 << e.id);
        chk("sb_data", md_rx_data, e.d);
        chk("sb_off", md_rx_offset, e.o);
        chk("sb_size", md_rx_size, e.s);
      end
    end
  end

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;

    reset       = 1'b1;
    md_rx_ready = 1'b1;
    md_rx_err   = 1'b0;
    cnt_clr     = 1'b0;
    req_data    = '0;
    req_offset  = '0;
    req_size    = '0;
    for (int i = 0; i < N; i++)
      set_req(i, 32'h1000_0000 + i, OFFW'(i), SIZEW'(i + 1));
    req_valid = 4'b1111;

    // reset held with everyone requesting
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_valid", md_rx_valid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_perr", proto_err, 0);
      chk("rst_cnt", grant_cnt, 0);
    end
    reset = 1'b0;
    #1;
    chk("rel_idle", md_rx_valid, 0);

    // round robin, back to back
    for (int k = 0; k < 5; k++)
      push(k % N);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("rr_grant", grant, rr_exp[k]);
      chk("rr_valid", md_rx_valid, 1);
    end
    @(negedge clk);
    do_reset();
    chk("rr_drain", sb.size(), 0);

    // backpressure on requester 2
    chk("bp_perr0", proto_err, 0);
    set_req(2, 32'hA5A5_0001, 2'd1, 3'd2);
    req_valid = 4'b0100;
    md_rx_err = 1'b1;
    push(2);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_grant", grant, 4'b0100);
      chk("bp_data", md_rx_data, 32'hA5A5_0001);
      chk("bp_off", md_rx_offset, 1);
      chk("bp_size", md_rx_size, 2);
      chk("bp_ready", req_ready, 0);
      chk("bp_err", req_err, 0);
      @(negedge clk);
    end
    md_rx_ready = 1'b1;
    #1;
    chk("bp_ready1", req_ready, 4'b0100);
    chk("bp_err1", req_err, 4'b0100);
    chk("bp_perr", proto_err, 0);
    @(negedge clk);
    do_reset();
    chk("bp_drain", sb.size(), 0);

    // pointer moves past the last owner
    set_req(3, 32'h3333_0003, 2'd3, 3'd4);
    set_req(0, 32'h0000_00C0, 2'd0, 3'd1);
    req_valid = 4'b1000;
    push(3);
    @(negedge clk);
    #1;
    chk("ptr_g3", grant, 4'b1000);
    req_valid   = 4'b1001;
    md_rx_ready = 1'b1;
    push(0);
    push(3);
    @(negedge clk);
    #1;
    chk("ptr_g0", grant, 4'b0001);
    @(negedge clk);
    #1;
    chk("ptr_g3b", grant, 4'b1000);
    @(negedge clk);
    do_reset();
    chk("ptr_drain", sb.size(), 0);

    // owner drops valid before ready
    set_req(1, 32'h1111_0001, 2'd2, 3'd3);
    req_valid = 4'b0010;
    @(negedge clk);
    #1;
    chk("pe_g1", grant, 4'b0010);
    req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("pe_set", proto_err, 1);
    chk("pe_idle", md_rx_valid, 0);
    chk("pe_gnt0", grant, 0);
    req_valid = 4'b0101;
    @(negedge clk);
    #1;
    chk("pe_next", grant, 4'b0100);
    chk("pe_hold", proto_err, 1);
    @(negedge clk);
    #1;
    chk("pe_hold2", proto_err, 1);
    do_reset();
    #1;
    chk("pe_clr", proto_err, 0);

    // completion counters
    sb_en = 1'b0;
    set_req(0, 32'h0000_0DD0, 2'd0, 3'd4);
    req_valid   = 4'b0001;
    md_rx_ready = 1'b1;
`ifdef MD_ARB_STATS_EN
    repeat (70001) @(negedge clk);
    #1;
    chk("cnt_sat", grant_cnt[15:0], 16'hFFFF);
    chk("cnt_rest", grant_cnt[63:16], 0);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("cnt_clr", grant_cnt[15:0], 0);
    @(negedge clk);
    #1;
    chk("cnt_one", grant_cnt[15:0], 1);
`else
    repeat (6) @(negedge clk);
    #1;
    chk("cnt_off", grant_cnt, 0);
    chk("cnt_run", grant, 4'b0001);
`endif
    @(negedge clk);
    do_reset();
    sb_en = 1'b1;
    #1;
    chk("end_idle", md_rx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
